jbi_pktin_dsm: RTL and testbench

JBus inbound packet disassembler and receiver. It is the receive-side counterpart of the outbound packet assembler/driver. It samples J_ADTYPE/J_AD/J_ADP from the IO pads and checks lane parity. It tracks packet framing (header cycle plus 0/1/4 data cycles) with a small state machine, then pushes decoded header and data beats to the inbound request queues. Error pulses and a saturating parity-error count go to the JBI CSR block.

---
 rtl/jbi_pktin_dsm.sv | 227 ++++++++++++++++++++++
 tb/tb_jbi_pktin_dsm.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jbi_pktin_dsm.sv
// JBus inbound packet disassembler: pad flops, lane parity check, packet framing FSM,
// header/data push to the inbound request queues, and parity/protocol error reporting.
module jbi_pktin_dsm #(
  parameter int PERR_CNT_W = 8,
  parameter int ADDR_W     = 43
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            io_jbi_j_adtype,
  input  logic [127:0]          io_jbi_j_ad,
  input  logic [3:0]            io_jbi_j_adp,
  input  logic                  csr_jbi_perr_chk_enb,
  input  logic                  csr_perr_cnt_clr,
  output logic                  pktin_hdr_vld,
  output logic [3:0]            pktin_hdr_cmd,
  output logic [5:0]            pktin_hdr_jid,
  output logic [ADDR_W-1:0]     pktin_hdr_addr,
  output logic [15:0]           pktin_hdr_be,
  output logic                  pktin_data_vld,
  output logic [127:0]          pktin_data,
  output logic                  pktin_data_last,
  output logic                  pktin_data_perr,
  output logic                  pktin_err_perr,
  output logic                  pktin_err_proto,
  output logic [PERR_CNT_W-1:0] pktin_perr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [1:0] TY_IDLE = 2'b00;
  localparam logic [1:0] TY_HDR  = 2'b01;
  localparam logic [1:0] TY_DATA = 2'b10;
  localparam logic [1:0] TY_RSVD = 2'b11;

  // Stage 0: pad flops, reset to an idle cycle
  logic [7:0]   adtype_q_reg;
  logic [127:0] ad_q_reg;
  logic [3:0]   adp_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      adtype_q_reg <= 8'h00;
      ad_q_reg     <= '0;
      adp_q_reg    <= 4'h0;
    end else begin
      adtype_q_reg <= io_jbi_j_adtype;
      ad_q_reg     <= io_jbi_j_ad;
      adp_q_reg    <= io_jbi_j_adp;
    end
  end

  // Stage 1 decode
  logic [3:0] perr_lane;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign perr_lane[gi] = ~^{ad_q_reg[32*gi +: 32], adtype_q_reg[2*gi +: 2], adp_q_reg[gi]};
    end
  endgenerate

  logic [1:0] cyc_type;
  logic [5:0] cyc_jid;
  logic       cyc_perr;
  logic [3:0] hdr_cmd;

  assign cyc_type = adtype_q_reg[7:6];
  assign cyc_jid  = adtype_q_reg[5:0];
  assign cyc_perr = (|perr_lane) & csr_jbi_perr_chk_enb & (cyc_type != TY_IDLE);
  assign hdr_cmd  = ad_q_reg[127:124];

  logic       cmd_ok;
  logic [2:0] cmd_beats;

  always_comb begin
    cmd_ok    = 1'b1;
    cmd_beats = 3'd0;
    case (hdr_cmd)
      4'h1:       cmd_beats = 3'd0;
      4'h2:       cmd_beats = 3'd4;
      4'h3, 4'h4: cmd_beats = 3'd1;
      default:    cmd_ok    = 1'b0;
    endcase
  end

  state_t     state_reg, state_next;
  logic [1:0] beat_cnt_reg, beat_cnt_next;
  logic [5:0] jid_reg, jid_next;
  logic       take_hdr;
  logic       hdr_push;
  logic       data_push;
  logic       data_last_next;
  logic       proto_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= 2'd0;
      jid_reg      <= 6'd0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      jid_reg      <= jid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    jid_next       = jid_reg;
    take_hdr       = 1'b0;
    hdr_push       = 1'b0;
    data_push      = 1'b0;
    data_last_next = 1'b0;
    proto_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        case (cyc_type)
          TY_HDR:  take_hdr   = 1'b1;
          TY_DATA: proto_next = 1'b1;
          TY_RSVD: proto_next = 1'b1;
          default: ;
        endcase
      end
      ST_DATA: begin
        case (cyc_type)
          TY_DATA: begin
            if (cyc_jid == jid_reg) begin
              data_push      = 1'b1;
              data_last_next = (beat_cnt_reg == 2'd0);
              if (beat_cnt_reg == 2'd0) begin
                state_next = ST_IDLE;
              end else begin
                beat_cnt_next = beat_cnt_reg - 2'd1;
              end
            end else begin
              proto_next = 1'b1;
              state_next = ST_DROP;
            end
          end
          // A new header abandons the packet and is then decoded normally
          TY_HDR: begin
            proto_next = 1'b1;
            take_hdr   = 1'b1;
          end
          default: begin
            proto_next = 1'b1;
            state_next = ST_IDLE;
          end
        endcase
      end
      ST_DROP: begin
        case (cyc_type)
          TY_HDR:  take_hdr = 1'b1;
          TY_IDLE: state_next = ST_IDLE;
          TY_RSVD: begin
            proto_next = 1'b1;
            state_next = ST_IDLE;
          end
          default: ;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase

    if (take_hdr) begin
      if (cyc_perr || !cmd_ok) begin
        proto_next = proto_next | ~cmd_ok;
        state_next = ST_DROP;
      end else begin
        hdr_push = 1'b1;
        if (cmd_beats == 3'd0) begin
          state_next = ST_IDLE;
        end else begin
          state_next    = ST_DATA;
          beat_cnt_next = 2'(cmd_beats - 3'd1);
          jid_next      = cyc_jid;
        end
      end
    end
  end

  // Registered outputs; payloads only load on their push
  always_ff @(posedge clk) begin
    if (rst) begin
      pktin_hdr_vld   <= 1'b0;
      pktin_hdr_cmd   <= 4'h0;
      pktin_hdr_jid   <= 6'd0;
      pktin_hdr_addr  <= '0;
      pktin_hdr_be    <= 16'h0;
      pktin_data_vld  <= 1'b0;
      pktin_data      <= '0;
      pktin_data_last <= 1'b0;
      pktin_data_perr <= 1'b0;
      pktin_err_perr  <= 1'b0;
      pktin_err_proto <= 1'b0;
      pktin_perr_cnt  <= '0;
    end else begin
      pktin_hdr_vld   <= hdr_push;
      pktin_data_vld  <= data_push;
      pktin_data_last <= data_push & data_last_next;
      pktin_data_perr <= data_push & cyc_perr;
      pktin_err_perr  <= cyc_perr;
      pktin_err_proto <= proto_next;
      if (hdr_push) begin
        pktin_hdr_cmd  <= hdr_cmd;
        pktin_hdr_jid  <= cyc_jid;
        pktin_hdr_addr <= ad_q_reg[ADDR_W-1:0];
        pktin_hdr_be   <= ad_q_reg[79:64];
      end
      if (data_push) begin
        pktin_data <= ad_q_reg;
      end
      if (csr_perr_cnt_clr) begin
        pktin_perr_cnt <= '0;
      end else if (cyc_perr && (pktin_perr_cnt != {PERR_CNT_W{1'b1}})) begin
        pktin_perr_cnt <= pktin_perr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jbi_pktin_dsm.sv
// Scoreboard bench for jbi_pktin_dsm: directed JBus cycles, expected pushes queued,
// a negedge monitor pops and compares every header/data push.
module tb_jbi_pktin_dsm;

  logic         clk;
  logic         rst;
  logic [7:0]   io_jbi_j_adtype;
  logic [127:0] io_jbi_j_ad;
  logic [3:0]   io_jbi_j_adp;
  logic         csr_jbi_perr_chk_enb;
  logic         csr_perr_cnt_clr;
  logic         pktin_hdr_vld;
  logic [3:0]   pktin_hdr_cmd;
  logic [5:0]   pktin_hdr_jid;
  logic [42:0]  pktin_hdr_addr;
  logic [15:0]  pktin_hdr_be;
  logic         pktin_data_vld;
  logic [127:0] pktin_data;
  logic         pktin_data_last;
  logic         pktin_data_perr;
  logic         pktin_err_perr;
  logic         pktin_err_proto;
  logic [7:0]   pktin_perr_cnt;

  jbi_pktin_dsm #(.PERR_CNT_W(8), .ADDR_W(43)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .io_jbi_j_adtype      (io_jbi_j_adtype),
    .io_jbi_j_ad          (io_jbi_j_ad),
    .io_jbi_j_adp         (io_jbi_j_adp),
    .csr_jbi_perr_chk_enb (csr_jbi_perr_chk_enb),
    .csr_perr_cnt_clr     (csr_perr_cnt_clr),
    .pktin_hdr_vld        (pktin_hdr_vld),
    .pktin_hdr_cmd        (pktin_hdr_cmd),
    .pktin_hdr_jid        (pktin_hdr_jid),
    .pktin_hdr_addr       (pktin_hdr_addr),
    .pktin_hdr_be         (pktin_hdr_be),
    .pktin_data_vld       (pktin_data_vld),
    .pktin_data           (pktin_data),
    .pktin_data_last      (pktin_data_last),
    .pktin_data_perr      (pktin_data_perr),
    .pktin_err_perr       (pktin_err_perr),
    .pktin_err_proto      (pktin_err_proto),
    .pktin_perr_cnt       (pktin_perr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_data;
    logic [3:0]   cmd;
    logic [5:0]   jid;
    logic [42:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
    logic         last;
    logic         perr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   perr_seen = 0;
  int   proto_seen = 0;
  int   exp_perr = 0;
  int   exp_proto = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [127:0] hdr_ad(input logic [3:0] cmd, input logic [42:0] addr,
                                          input logic [15:0] be);
    logic [127:0] a;
    a = '0;
    a[127:124] = cmd;
    a[79:64]   = be;
    a[42:0]    = addr;
    return a;
  endfunction

  function automatic logic [127:0] mkdata(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(k);
    return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(k) * 32'd3};
  endfunction

  task automatic exp_hdr(input logic [3:0] cmd, input logic [5:0] jid, input logic [42:0] addr,
                         input logic [15:0] be);
    exp_t e;
    e = '{is_data: 1'b0, cmd: cmd, jid: jid, addr: addr, be: be, data: '0, last: 1'b0, perr: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic exp_data(input logic [127:0] d, input logic last, input logic perr);
    exp_t e;
    e = '{is_data: 1'b1, cmd: 4'h0, jid: 6'd0, addr: '0, be: 16'h0, data: d, last: last, perr: perr};
    exp_q.push_back(e);
  endtask

  // One JBus cycle with good odd parity, optionally corrupted lanes via flip
  task automatic cyc(input logic [7:0] adtype, input logic [127:0] ad, input logic [3:0] flip);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = (~^{ad[32*i +: 32], adtype[2*i +: 2]}) ^ flip[i];
    end
    io_jbi_j_adtype = adtype;
    io_jbi_j_ad     = ad;
    io_jbi_j_adp    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, '0, 4'h0);
  endtask

  task automatic settle(input string tag);
    idle(4);
    check({tag, "_queue_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_err_perr_pulses"}, 128'(perr_seen), 128'(exp_perr));
    check({tag, "_err_proto_pulses"}, 128'(proto_seen), 128'(exp_proto));
  endtask

  // Monitor: pops one expected push per observed valid
  always @(negedge clk) begin
    exp_t e;
    if (pktin_err_perr === 1'b1) perr_seen++;
    if (pktin_err_proto === 1'b1) proto_seen++;
    if (pktin_hdr_vld === 1'b1 && pktin_data_vld === 1'b1) begin
      total++;
      bad++;
      $display("FAIL both_valids act=11 req=not both");
    end else if (pktin_hdr_vld === 1'b1 || pktin_data_vld === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_push act hdr=%b data=%b req=no push", pktin_hdr_vld, pktin_data_vld);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_data) begin
          if (pktin_hdr_vld !== 1'b1 || pktin_hdr_cmd !== e.cmd || pktin_hdr_jid !== e.jid ||
              pktin_hdr_addr !== e.addr || pktin_hdr_be !== e.be) begin
            bad++;
            $display("FAIL hdr_push act vld=%b cmd=%h jid=%h addr=%h be=%h req cmd=%h jid=%h addr=%h be=%h",
                     pktin_hdr_vld, pktin_hdr_cmd, pktin_hdr_jid, pktin_hdr_addr, pktin_hdr_be,
                     e.cmd, e.jid, e.addr, e.be);
          end else begin
            $display("ok   hdr_push cmd=%h jid=%h addr=%h", pktin_hdr_cmd, pktin_hdr_jid, pktin_hdr_addr);
          end
        end else begin
          if (pktin_data_vld !== 1'b1 || pktin_data !== e.data || pktin_data_last !== e.last ||
              pktin_data_perr !== e.perr) begin
            bad++;
            $display("FAIL data_push act vld=%b data=%h last=%b perr=%b req data=%h last=%b perr=%b",
                     pktin_data_vld, pktin_data, pktin_data_last, pktin_data_perr,
                     e.data, e.last, e.perr);
          end else begin
            $display("ok   data_push data=%h last=%b perr=%b", pktin_data, pktin_data_last, pktin_data_perr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    io_jbi_j_adtype = 8'h00;
    io_jbi_j_ad = '0;
    io_jbi_j_adp = 4'h0;
    csr_jbi_perr_chk_enb = 1'b1;
    csr_perr_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_vld", 128'(pktin_hdr_vld), 128'(0));
    check("rst_data_vld", 128'(pktin_data_vld), 128'(0));
    check("rst_perr_cnt", 128'(pktin_perr_cnt), 128'(0));
    check("rst_data", pktin_data, 128'(0));
    rst = 1'b0;
    idle(2);

    // Read header, no data
    exp_hdr(4'h1, 6'd5, 43'h123_4567_89AB, 16'hFFFF);
    cyc(8'h45, hdr_ad(4'h1, 43'h123_4567_89AB, 16'hFFFF), 4'h0);
    settle("read");

    // Write line, 4 beats back to back
    exp_hdr(4'h2, 6'd9, 43'h0AA_0000_0040, 16'hFFFF);
    cyc(8'h49, hdr_ad(4'h2, 43'h0AA_0000_0040, 16'hFFFF), 4'h0);
    for (int k = 0; k < 4; k++) begin
      exp_data(mkdata(k), k == 3, 1'b0);
      cyc(8'h89, mkdata(k), 4'h0);
    end
    settle("wrline");

    // Parity error on beat 2 (adp[2] flipped)
    exp_hdr(4'h2, 6'd9, 43'h0AA_0000_0080, 16'h00FF);
    cyc(8'h49, hdr_ad(4'h2, 43'h0AA_0000_0080, 16'h00FF), 4'h0);
    for (int k = 0; k < 4; k++) begin
      exp_data(mkdata(10 + k), k == 3, k == 1);
      cyc(8'h89, mkdata(10 + k), (k == 1) ? 4'b0100 : 4'b0000);
    end
    exp_perr += 1;
    settle("perr_beat");
    check("perr_cnt_one", 128'(pktin_perr_cnt), 128'(1));

    // Same corruption with checking disabled
    csr_jbi_perr_chk_enb = 1'b0;
    exp_hdr(4'h2, 6'd9, 43'h0AA_0000_00C0, 16'hF0F0);
    cyc(8'h49, hdr_ad(4'h2, 43'h0AA_0000_00C0, 16'hF0F0), 4'h0);
    for (int k = 0; k < 4; k++) begin
      exp_data(mkdata(20 + k), k == 3, 1'b0);
      cyc(8'h89, mkdata(20 + k), (k == 1) ? 4'b0100 : 4'b0000);
    end
    settle("perr_disabled");
    check("perr_cnt_hold", 128'(pktin_perr_cnt), 128'(1));
    csr_jbi_perr_chk_enb = 1'b1;

    // Truncated write line followed directly by a read header
    exp_hdr(4'h2, 6'd9, 43'h000_0000_1000, 16'hFFFF);
    cyc(8'h49, hdr_ad(4'h2, 43'h000_0000_1000, 16'hFFFF), 4'h0);
    exp_data(mkdata(30), 1'b0, 1'b0);
    cyc(8'h89, mkdata(30), 4'h0);
    exp_data(mkdata(31), 1'b0, 1'b0);
    cyc(8'h89, mkdata(31), 4'h0);
    exp_hdr(4'h1, 6'd7, 43'h000_0000_2000, 16'h0001);
    cyc(8'h47, hdr_ad(4'h1, 43'h000_0000_2000, 16'h0001), 4'h0);
    exp_proto += 1;
    settle("truncate");

    // JID mismatch mid-packet: rest dropped until idle
    exp_hdr(4'h2, 6'd9, 43'h000_0000_3000, 16'hFFFF);
    cyc(8'h49, hdr_ad(4'h2, 43'h000_0000_3000, 16'hFFFF), 4'h0);
    exp_data(mkdata(40), 1'b0, 1'b0);
    cyc(8'h89, mkdata(40), 4'h0);
    cyc(8'h83, mkdata(41), 4'h0);
    cyc(8'h89, mkdata(42), 4'h0);
    cyc(8'h89, mkdata(43), 4'h0);
    exp_proto += 1;
    settle("jid_mismatch");

    // Lone data cycle in IDLE
    cyc(8'h89, mkdata(50), 4'h0);
    exp_proto += 1;
    settle("data_in_idle");

    // Unsupported command
    cyc(8'h45, hdr_ad(4'h5, 43'h000_0000_4000, 16'hFFFF), 4'h0);
    exp_proto += 1;
    settle("bad_cmd");

    // Saturate the counter with 300 parity-bad headers
    for (int k = 0; k < 300; k++) cyc(8'h45, hdr_ad(4'h1, 43'(k), 16'h0), 4'b0001);
    exp_perr += 300;
    settle("saturate");
    check("perr_cnt_sat", 128'(pktin_perr_cnt), 128'(8'hFF));

    // Clear coincides with the decode of a perr cycle
    cyc(8'h45, hdr_ad(4'h1, 43'h1, 16'h0), 4'b0010);
    csr_perr_cnt_clr = 1'b1;
    cyc(8'h00, '0, 4'h0);
    csr_perr_cnt_clr = 1'b0;
    exp_perr += 1;
    settle("clr");
    check("perr_cnt_clr", 128'(pktin_perr_cnt), 128'(0));
    cyc(8'h45, hdr_ad(4'h1, 43'h2, 16'h0), 4'b1000);
    exp_perr += 1;
    settle("after_clr");
    check("perr_cnt_after_clr", 128'(pktin_perr_cnt), 128'(1));

    // Reset in the middle of a write line
    exp_hdr(4'h2, 6'd9, 43'h000_0000_5000, 16'hFFFF);
    cyc(8'h49, hdr_ad(4'h2, 43'h000_0000_5000, 16'hFFFF), 4'h0);
    cyc(8'h89, mkdata(60), 4'h0);
    rst = 1'b1;
    cyc(8'h89, mkdata(61), 4'h0);
    cyc(8'h89, mkdata(62), 4'h0);
    check("midrst_hdr_vld", 128'(pktin_hdr_vld), 128'(0));
    check("midrst_data_vld", 128'(pktin_data_vld), 128'(0));
    check("midrst_perr_cnt", 128'(pktin_perr_cnt), 128'(0));
    check("midrst_hdr_addr", 128'(pktin_hdr_addr), 128'(0));
    check("midrst_data", pktin_data, 128'(0));
    rst = 1'b0;
    exp_hdr(4'h1, 6'd12, 43'h7FF_FFFF_FFFF, 16'hABCD);
    cyc(8'h4C, hdr_ad(4'h1, 43'h7FF_FFFF_FFFF, 16'hABCD), 4'h0);
    settle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
